piso_sipo_universal_shift_register: RTL
=======================================

// Module: piso_sipo_universal_shift_register
// PURPOSE
//  - Parametrised universal shift register; the WIDTH-bit generalisation of the 4-bit serial shifter.
//  - Modes: hold, shift right, shift left, parallel load.
//  - Provides a shift counter and a registered word-done pulse, so serial framing logic knows when a full word has moved.
//  - Sits between serial links and parallel datapaths as a SIPO/PISO converter.
// PARAMETERS
//  WIDTH      4                 register width in bits, >= 2
//  RESET_VAL  {WIDTH{1'b0}}     value loaded into q on reset
// PORTS
//  clk      input   1       rising-edge clock
//  reset    input   1       asynchronous, active-low reset
//  en       input   1       1 = act on mode this edge; 0 = hold everything
//  mode     input   2       00 hold, 01 shift right, 10 shift left, 11 parallel load
//  sin_r    input   1       serial in for shift right, enters q[WIDTH-1]
//  sin_l    input   1       serial in for shift left, enters q[0]
//  pin      input   WIDTH   parallel load data
//  rot      input   1       rotate select (used only with SHREG_ROTATE_EN)
//  q        output  WIDTH   register contents
//  sout_r   output  1       q[0]; serial out for right shifts
//  sout_l   output  1       q[WIDTH-1]; serial out for left shifts
//  done     output  1       one-cycle pulse after the WIDTH-th shift since last load/reset
// BEHAVIOUR
//  - Reset (reset=0, async, any time incl. mid-shift):
//    - q = RESET_VAL, cnt = 0, done = 0.
//    - Released synchronously on the next clk edge after reset=1.
//  - All state updates on posedge clk; q, cnt, done are registered; sout_r/sout_l are combinational from q.
//  - en=0 or mode=00: q and cnt hold; done=0.
//  - mode=01 (shift right): q <= {sin_r, q[WIDTH-1:1]}.
//  - mode=10 (shift left):  q <= {q[WIDTH-2:0], sin_l}.
//  - mode=11 (load): q <= pin; cnt <= 0; done <= 0.
//  - Serial latency: bit on sin_r appears on sout_r after WIDTH shift edges; same for sin_l -> sout_l.
//  - Shift counter:
//    - cnt width $clog2(WIDTH+1); incremented on each shift (01/10 with en=1).
//    - On the shift where cnt==WIDTH-1: cnt <= 0, done <= 1 for exactly one cycle.
//    - Any other edge: done <= 0.
//    - Mixing right and left shifts counts each shift equally.
//  - A load during a partial word discards the count; no done for that partial word.
//  - Direction change mid-word is legal; data moves as the mode dictates.
// CONFIGURATION
//  - SHREG_ROTATE_EN defined:
//    - With rot=1, shifts are circular: right uses q[0] as the new MSB; left uses q[WIDTH-1] as the new LSB.
//    - sin_r/sin_l are ignored; the counter and done behave as for normal shifts.
//  - SHREG_ROTATE_EN undefined: rot port present but ignored; all shifts use sin_r/sin_l.
// TESTING (WIDTH=4, RESET_VAL=0)
//  1. Load 4'b1111, shift once, drive reset=0 between edges:
//     -> q=0000, done=0 immediately; first shift after release is counted as shift 1.
//  2. en=1, mode=01, sin_r=1,0,1,1 on 4 edges:
//     -> q=4'b1101, sout_r=1; done=1 for one cycle only after 4th edge.
//  3. Load pin=4'b1010, then mode=10, sin_l=0 for 2 edges:
//     -> q=0100 then 1000; sout_l=1,0,1; no done.
//  4. en=0, mode=01 for 3 edges after q=4'b0110:
//     -> q stays 0110, done stays 0, cnt unchanged (next 4 shifts give done on 4th).
//  5. 2 right shifts, then load 4'b0011, then 4 shifts:
//     -> no done at load; done only on the 4th post-load shift.
//  6. SHREG_ROTATE_EN defined: load 4'b0001, mode=01, rot=1, sin_r=0, 4 edges
//     -> q=1000,0100,0010,0001; done on 4th. Macro undefined: same stimulus -> q=0000 after 1st edge.

Source files
------------

// File: rtl/piso_sipo_universal_shift_register.sv
// Universal WIDTH-bit shift register: hold, shift right/left, parallel load.
// Define SHREG_ROTATE_EN to enable circular shifts selected by rot.
module piso_sipo_universal_shift_register #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;
    logic          msb_in;
    logic          lsb_in;

`ifdef SHREG_ROTATE_EN
    always_comb begin
        msb_in = sin_r;
        lsb_in = sin_l;
        if (rot) begin
            msb_in = q[0];
            lsb_in = q[WIDTH-1];
        end
    end
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign msb_in     = sin_r;
    assign lsb_in     = sin_l;
`endif

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                unique case (mode)
                    2'b00: ;
                    2'b01: q <= {msb_in, q[WIDTH-1:1]};
                    2'b10: q <= {q[WIDTH-2:0], lsb_in};
                    2'b11: begin
                        q   <= pin;
                        cnt <= '0;
                    end
                endcase
                // both shift directions share one word counter
                if (mode == 2'b01 || mode == 2'b10) begin
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
